apb_gpio_arbiter: RTL and testbench
===================================

Name: apb_gpio_arbiter

Overview:
- Round-robin APB master that shares the single APB slave port of the GPIO peripheral between NUM_REQ on-chip requesters (e.g. core, debug, DMA, power manager).
- Each requester issues one single-beat register read or write through a valid/ready request channel and gets a one-cycle response pulse.
- Sits between the requesters and the GPIO slave's PADDR/PWDATA/PWRITE/PSEL/PENABLE/PRDATA/PREADY/PSLVERR.
- Adds an access timeout so a hung slave cannot starve the other requesters.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_WIDTH, 12, APB address width.
- DATA_WIDTH, 32, APB data width.
- TIMEOUT_CYCLES, 16, maximum ACCESS cycles with PREADY low before abort (>=2).

Ports:
- HCLK  in  1  clock.
- HRESETn  in  1  reset, synchronous, active-low.
- req_valid_i  in  NUM_REQ  per-requester request valid.
- req_write_i  in  NUM_REQ  1=write, 0=read.
- req_addr_i  in  NUM_REQ x ADDR_WIDTH  byte address.
- req_wdata_i  in  NUM_REQ x DATA_WIDTH  write data.
- req_ready_o  out  NUM_REQ  one-hot accept pulse.
- rsp_valid_o  out  NUM_REQ  one-hot response pulse.
- rsp_rdata_o  out  DATA_WIDTH  read data, shared, valid with rsp_valid_o.
- rsp_err_o  out  1  error, shared, valid with rsp_valid_o.
- PADDR  out  ADDR_WIDTH  APB address.
- PWDATA  out  DATA_WIDTH  APB write data.
- PWRITE  out  1  APB direction.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PRDATA  in  DATA_WIDTH  APB read data.
- PREADY  in  1  APB ready.
- PSLVERR  in  1  APB error.
- busy_o  out  1  1 whenever the FSM is not in IDLE.

Behaviour:
- Reset:
  - All outputs are 0.
  - The FSM goes to IDLE.
  - Round-robin pointer = NUM_REQ-1, so requester 0 wins first.
  - The timeout counter is 0.
  - Reset asserted mid-transaction drops PSEL/PENABLE at the next edge and emits no response.
- Requester rule: req_valid_i[i] and its addr/wdata/write hold stable until req_ready_o[i]. The arbiter never accepts a request it has not granted.
- Arbitration: priority search starts at pointer+1 and wraps modulo NUM_REQ. The pointer updates to the granted index only on grant.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - Any valid request: grant index g, pulse req_ready_o[g] for 1 cycle, capture addr/wdata/write/g into registers.
  - If captured addr[1:0] != 0, go to RESP with err=1, rdata=0 and no APB access.
  - Otherwise go to SETUP.
- SETUP: PSEL=1, PENABLE=0 for exactly 1 cycle, then ACCESS.
- ACCESS:
  - PSEL=1, PENABLE=1.
  - On PREADY=1, capture PRDATA (reads only; writes give rdata=0) and PSLVERR, then go to RESP.
  - The counter increments each cycle with PREADY=0.
  - When it reaches TIMEOUT_CYCLES, abort: PSEL/PENABLE drop, err=1, rdata=0, go to RESP.
- RESP: rsp_valid_o[g]=1 for 1 cycle with rsp_rdata_o/rsp_err_o, then IDLE. No new grant is made in RESP.
- Latency: accept at cycle T, SETUP at T+1, ACCESS at T+2, rsp_valid at T+3 with zero wait states. Each wait state adds 1 cycle. Back-to-back grants occur every 4 cycles minimum.
- APB signals:
  - PADDR/PWDATA/PWRITE come from the captured registers.
  - They are stable through SETUP and ACCESS and hold their last value in IDLE.
  - PSEL/PENABLE are 0 outside SETUP/ACCESS.
- rsp_rdata_o/rsp_err_o hold their value outside RESP. They are meaningful only with rsp_valid_o.
- Simultaneous requests: only one grant per IDLE cycle. Losing requesters keep valid and are served in pointer order. No requester waits more than NUM_REQ-1 transactions.

Decomposition:
- Package apb_gpio_arb_pkg holds:
  - the state enum (IDLE, SETUP, ACCESS, RESP);
  - default parameter constants;
  - the request struct (write, addr, wdata).
- One sub-module, apb_gpio_rr_arb:
  - combinational round-robin priority picker plus pointer register;
  - inputs: req vector and grant-enable;
  - outputs: one-hot grant and index.

Test Plan:
1. Req0 write addr 0x004, data 0xA5A5_0001, PREADY tied 1 -> req_ready_o=0001 at T; PSEL=1/PENABLE=0 at T+1; PENABLE=1 at T+2 with PADDR=0x004, PWRITE=1; rsp_valid_o=0001, rsp_err_o=0 at T+3.
2. All 4 requesters hold valid reads -> grants in order 0,1,2,3,0, spaced exactly 4 cycles apart; each rsp_rdata_o equals the PRDATA driven for that access.
3. Req2 read 0x008, PREADY low 3 ACCESS cycles then high with PRDATA=0xDEAD_BEEF -> rsp_valid_o=0100 at T+6, rdata=0xDEAD_BEEF, err=0.
4. PREADY held 0 for 20 cycles, TIMEOUT_CYCLES=16 -> PSEL drops after 16 ACCESS cycles; rsp_err_o=1, rdata=0; next requester then granted normally.
5. PSLVERR=1 with PREADY=1 on req1 write -> rsp_err_o=1; misaligned addr 0x006 -> rsp at T+1 with err=1 and PSEL never asserted.
6. HRESETn=0 during ACCESS of req3 -> next edge PSEL=PENABLE=0, no rsp_valid_o; after release, req0 and req3 both valid -> req0 granted first.

Source files
------------

// File: rtl/apb_gpio_arb_pkg.sv
// apb_gpio_arb_pkg: shared state encoding, default sizes and request type for the APB GPIO arbiter
package apb_gpio_arb_pkg;
  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_ADDR_WIDTH = 12;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_TIMEOUT_CYCLES = 16;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
  typedef struct packed {
    logic write;
    logic [DEF_ADDR_WIDTH-1:0] addr;
    logic [DEF_DATA_WIDTH-1:0] wdata;
  } req_t;
endpackage

// File: rtl/apb_gpio_rr_arb.sv
// apb_gpio_rr_arb: round-robin priority picker starting after the last grant, with its pointer register
module apb_gpio_rr_arb #(
  parameter int NUM_REQ = 4,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IW-1:0] idx
);
  logic [IW-1:0] ptr;
  logic found;
  int j;
  always_comb begin
    idx = '0;
    found = 1'b0;
    j = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      j = int'(ptr) + k;
      j = j >= NUM_REQ ? j - NUM_REQ : j;
      if (!found && req[IW'(j)]) begin
        found = 1'b1;
        idx = IW'(j);
      end
    end
    gnt = '0;
    gnt[idx] = en && found;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) ptr <= IW'(NUM_REQ - 1);
    else if (en && found) ptr <= idx;
  end
endmodule

// File: rtl/apb_gpio_arbiter.sv
// apb_gpio_arbiter: round-robin APB master sharing one GPIO slave port between several requesters
module apb_gpio_arbiter
  import apb_gpio_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic HCLK,
  input  logic HRESETn,
  input  logic [NUM_REQ-1:0] req_valid_i,
  input  logic [NUM_REQ-1:0] req_write_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata_i,
  output logic [NUM_REQ-1:0] req_ready_o,
  output logic [NUM_REQ-1:0] rsp_valid_o,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic rsp_err_o,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  output logic PWRITE,
  output logic PSEL,
  output logic PENABLE,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic PREADY,
  input  logic PSLVERR,
  output logic busy_o
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  state_t state;
  logic [NUM_REQ-1:0] gnt, sel;
  logic [IW-1:0] idx;
  logic [CW-1:0] cnt;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic write;
  apb_gpio_rr_arb #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk(HCLK),
    .rst_n(HRESETn),
    .req(req_valid_i),
    .en(state == IDLE && HRESETn),
    .gnt(gnt),
    .idx(idx)
  );
  always_comb begin
    addr = '0;
    wdata = '0;
    write = 1'b0;
    for (int i = 0; i < NUM_REQ; i++)
      if (idx == IW'(i)) begin
        addr = req_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        wdata = req_wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
        write = req_write_i[i];
      end
  end
  assign req_ready_o = gnt;
  assign busy_o = state != IDLE;
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state <= IDLE;
      sel <= '0;
      cnt <= '0;
      PADDR <= '0;
      PWDATA <= '0;
      PWRITE <= 1'b0;
      PSEL <= 1'b0;
      PENABLE <= 1'b0;
      rsp_valid_o <= '0;
      rsp_rdata_o <= '0;
      rsp_err_o <= 1'b0;
    end else begin
      rsp_valid_o <= '0;
      case (state)
        IDLE: if (|gnt) begin
          sel <= gnt;
          PADDR <= addr;
          PWDATA <= wdata;
          PWRITE <= write;
          // misaligned accesses are answered locally without touching the bus
          if (addr[1:0] != 2'b00) begin
            state <= RESP;
            rsp_valid_o <= gnt;
            rsp_err_o <= 1'b1;
            rsp_rdata_o <= '0;
          end else begin
            state <= SETUP;
            PSEL <= 1'b1;
          end
        end
        SETUP: begin
          state <= ACCESS;
          PENABLE <= 1'b1;
        end
        ACCESS: if (PREADY || cnt == CW'(TIMEOUT_CYCLES - 1)) begin
          state <= RESP;
          PSEL <= 1'b0;
          PENABLE <= 1'b0;
          cnt <= '0;
          rsp_valid_o <= sel;
          rsp_err_o <= !PREADY || PSLVERR;
          rsp_rdata_o <= PREADY && !PWRITE ? PRDATA : '0;
        end else cnt <= cnt + 1'b1;
        RESP: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_apb_gpio_arbiter.sv
// tb_apb_gpio_arbiter: directed and random transactions checked against a transaction-level model
module tb_apb_gpio_arbiter;
  localparam int N = 4, AW = 12, DW = 32, TO = 16;
  logic HCLK = 1'b0, HRESETn = 1'b0;
  logic [N-1:0] req_valid, req_write, req_ready, rsp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [DW-1:0] rsp_rdata, PWDATA, PRDATA = '0;
  logic [AW-1:0] PADDR;
  logic rsp_err, PWRITE, PSEL, PENABLE, busy, PREADY = 1'b0, PSLVERR = 1'b0;
  logic v[N], wr[N];
  logic [AW-1:0] a[N];
  logic [DW-1:0] wd[N];
  int ptr = N - 1, errors = 0, checks = 0, w;
  always #5 HCLK = ~HCLK;
  always_comb begin
    req_valid = '0;
    req_write = '0;
    req_addr = '0;
    req_wdata = '0;
    for (int i = 0; i < N; i++) begin
      req_valid[i] = v[i];
      req_write[i] = wr[i];
      req_addr[i*AW +: AW] = a[i];
      req_wdata[i*DW +: DW] = wd[i];
    end
  end
  apb_gpio_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .req_valid_i(req_valid), .req_write_i(req_write), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .req_ready_o(req_ready), .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
    .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR), .busy_o(busy)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge HCLK);
    #1;
  endtask
  // one full transaction from an IDLE cycle; the slave answers after `waits` ACCESS cycles
  task automatic run(input int waits, input logic [DW-1:0] prd, input logic slv, input bit keep);
    int g;
    logic [N-1:0] oh;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic ew;
    bit tmo;
    g = -1;
    for (int k = 1; k <= N; k++) if (g < 0 && v[(ptr + k) % N]) g = (ptr + k) % N;
    #4;
    if (g < 0) begin
      chk("no_grant", req_ready, 0);
      tick;
      return;
    end
    oh = '0;
    oh[g] = 1'b1;
    chk("ready", req_ready, oh);
    chk("idle_busy", busy, 0);
    chk("idle_psel", {PSEL, PENABLE}, 0);
    ptr = g;
    ea = a[g];
    ed = wd[g];
    ew = wr[g];
    tmo = waits >= TO;
    tick;
    if (!keep) v[g] = 1'b0;
    if (ea[1:0] != 2'b00) begin
      #4;
      chk("mis_rsp", rsp_valid, oh);
      chk("mis_err", rsp_err, 1);
      chk("mis_rdata", rsp_rdata, 0);
      chk("mis_psel", {PSEL, PENABLE}, 0);
      tick;
      return;
    end
    #4;
    chk("setup_sel", {PSEL, PENABLE}, 2'b10);
    chk("setup_addr", PADDR, ea);
    chk("setup_write", PWRITE, ew);
    chk("setup_wdata", PWDATA, ed);
    chk("setup_rsp", rsp_valid, 0);
    chk("setup_busy", busy, 1);
    tick;
    for (int k = 0; k < TO; k++) begin
      PREADY = k >= waits;
      PRDATA = PREADY ? prd : $urandom;
      PSLVERR = PREADY ? slv : 1'($urandom);
      #4;
      chk("access_sel", {PSEL, PENABLE}, 2'b11);
      chk("access_addr", PADDR, ea);
      chk("access_rsp", rsp_valid, 0);
      tick;
      if (PREADY) break;
    end
    PREADY = 1'b0;
    PSLVERR = 1'b0;
    #4;
    chk("rsp_valid", rsp_valid, oh);
    chk("rsp_err", rsp_err, tmo ? 1'b1 : slv);
    chk("rsp_rdata", rsp_rdata, (tmo || ew) ? '0 : prd);
    chk("rsp_psel", {PSEL, PENABLE}, 0);
    tick;
  endtask
  initial begin
    for (int i = 0; i < N; i++) begin
      v[i] = 1'b0;
      wr[i] = 1'b0;
      a[i] = '0;
      wd[i] = '0;
    end
    tick;
    tick;
    #4;
    chk("rst_ready", req_ready, 0);
    chk("rst_rsp", rsp_valid, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_err", rsp_err, 0);
    chk("rst_apb", {PADDR, PWRITE, PSEL, PENABLE}, 0);
    chk("rst_pwdata", PWDATA, 0);
    chk("rst_busy", busy, 0);
    tick;
    HRESETn = 1'b1;
    tick;
    v[0] = 1'b1; wr[0] = 1'b1; a[0] = 12'h004; wd[0] = 32'hA5A5_0001;
    run(0, '0, 1'b0, 1'b0);
    for (int i = 0; i < N; i++) begin
      v[i] = 1'b1; wr[i] = 1'b0; a[i] = AW'(12'h010 + 4 * i); wd[i] = $urandom;
    end
    for (int n = 0; n < 5; n++) run(0, 32'h1000_0000 + n, 1'b0, 1'b1);
    for (int i = 0; i < N; i++) v[i] = 1'b0;
    v[2] = 1'b1; wr[2] = 1'b0; a[2] = 12'h008;
    run(3, 32'hDEAD_BEEF, 1'b0, 1'b0);
    v[3] = 1'b1; wr[3] = 1'b0; a[3] = 12'h00C;
    run(20, 32'h1234_5678, 1'b0, 1'b0);
    v[0] = 1'b1; wr[0] = 1'b0; a[0] = 12'h010;
    run(0, 32'h0BAD_F00D, 1'b0, 1'b0);
    v[1] = 1'b1; wr[1] = 1'b1; a[1] = 12'h020; wd[1] = 32'h5555_AAAA;
    run(0, '0, 1'b1, 1'b0);
    v[2] = 1'b1; wr[2] = 1'b0; a[2] = 12'h006;
    run(0, '0, 1'b0, 1'b0);
    v[3] = 1'b1; wr[3] = 1'b0; a[3] = 12'h030;
    #4;
    chk("r6_ready", req_ready, 4'b1000);
    tick;
    v[3] = 1'b0;
    tick;
    #4;
    chk("r6_access", {PSEL, PENABLE}, 2'b11);
    HRESETn = 1'b0;
    tick;
    #4;
    chk("r6_psel", {PSEL, PENABLE}, 0);
    chk("r6_rsp", rsp_valid, 0);
    chk("r6_busy", busy, 0);
    chk("r6_paddr", PADDR, 0);
    ptr = N - 1;
    tick;
    #4;
    chk("r6_rsp2", rsp_valid, 0);
    tick;
    HRESETn = 1'b1;
    v[0] = 1'b1; wr[0] = 1'b0; a[0] = 12'h040;
    v[3] = 1'b1; wr[3] = 1'b0; a[3] = 12'h044;
    run(0, 32'hC0DE_0000, 1'b0, 1'b0);
    run(1, 32'hC0DE_0003, 1'b0, 1'b0);
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < N; i++)
        if (!v[i] && $urandom_range(0, 1) == 1) begin
          v[i] = 1'b1;
          wr[i] = 1'($urandom);
          a[i] = AW'($urandom);
          if ($urandom_range(0, 3) != 0) a[i][1:0] = 2'b00;
          wd[i] = $urandom;
        end
      if (!(v[0] || v[1] || v[2] || v[3])) v[$urandom_range(0, N - 1)] = 1'b1;
      w = $urandom_range(0, 9) == 0 ? $urandom_range(16, 20) : $urandom_range(0, 4);
      run(w, $urandom, 1'($urandom_range(0, 3) == 0), 1'b0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
